// File: rtl/nec_operand_fetch.sv
// Operand fetch stage: pulls displacement then immediate bytes out of the circular
// prefetch queue, assembles them little-endian and owns the fetch pc.
module nec_operand_fetch #(
  parameter int QUEUE_DEPTH     = 8,
  parameter int MAX_DISP        = 2,
  parameter int MAX_IMM         = 4,
  parameter int BYTES_PER_CYCLE = 1,
  parameter int ALL_AT_ONCE     = 0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         ce_1,
  input  logic                         ce_2,
  input  logic                         set_pc,
  input  logic [15:0]                  new_pc,
  input  logic                         start,
  input  logic [2:0]                   disp_size,
  input  logic [2:0]                   imm_size,
  input  logic                         retire,
  input  logic [$clog2(QUEUE_DEPTH):0] ipq_len,
  input  logic [QUEUE_DEPTH-1:0][7:0]  ipq,
  output logic [15:0]                  pc,
  output logic                         busy,
  output logic                         valid,
  output logic [15:0]                  disp,
  output logic [31:0]                  imm,
  output logic [15:0]                  end_pc,
  output logic                         size_err
);

  localparam int         QW   = $clog2(QUEUE_DEPTH);
  localparam logic [2:0] DMAX = 3'(MAX_DISP);
  localparam logic [2:0] IMAX = 3'(MAX_IMM);
  localparam logic [7:0] BPC  = 8'(BYTES_PER_CYCLE);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] end_pc_q, end_pc_d;
  logic [15:0] disp_q, disp_d;
  logic [31:0] imm_q, imm_d;
  logic [2:0]  dsz_q, dsz_d;
  logic [3:0]  rem_q, rem_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        size_err_q, size_err_d;

  logic [2:0]  dsat, isat;
  logic [3:0]  rem_new;
  logic        over, accept;
  logic [7:0]  rem8, len8, avail8, take8, cnt8, lim8, dsz8;

  assign dsat    = (disp_size > DMAX) ? DMAX : disp_size;
  assign isat    = (imm_size > IMAX) ? IMAX : imm_size;
  assign over    = (disp_size > DMAX) || (imm_size > IMAX);
  assign rem_new = {1'b0, dsat} + {1'b0, isat};
  assign accept  = start && ((state_q == IDLE) || ((state_q == DONE) && retire));

  assign rem8   = {4'd0, rem_q};
  assign cnt8   = {4'd0, cnt_q};
  assign dsz8   = {5'd0, dsz_q};
  assign len8   = 8'(ipq_len);
  assign avail8 = (len8 < rem8) ? len8 : rem8;
  // All-at-once mode waits for the whole remainder; otherwise take what fits.
  assign take8  = (ALL_AT_ONCE != 0) ? ((len8 >= rem8) ? rem8 : 8'd0)
                                     : ((avail8 < BPC) ? avail8 : BPC);
  assign lim8   = cnt8 + take8;

  // Each output byte knows its stream position; it is written when that
  // position falls inside this cycle's window [cnt, cnt+take).
  logic [1:0]      d_hit;
  logic [1:0][7:0] d_byte;
  logic [3:0]      i_hit;
  logic [3:0][7:0] i_byte;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_disp
      if (gi < MAX_DISP) begin : g_on
        logic [7:0]    pos;
        logic [QW-1:0] qidx;
        assign pos        = 8'(gi);
        assign qidx       = pc_q[QW-1:0] + pos[QW-1:0] - cnt8[QW-1:0];
        assign d_hit[gi]  = (pos < dsz8) && (pos >= cnt8) && (pos < lim8);
        assign d_byte[gi] = ipq[qidx];
      end else begin : g_off
        assign d_hit[gi]  = 1'b0;
        assign d_byte[gi] = 8'd0;
      end
    end

    for (gi = 0; gi < 4; gi++) begin : g_imm
      if (gi < MAX_IMM) begin : g_on
        logic [7:0]    pos;
        logic [QW-1:0] qidx;
        assign pos        = dsz8 + 8'(gi);
        assign qidx       = pc_q[QW-1:0] + pos[QW-1:0] - cnt8[QW-1:0];
        assign i_hit[gi]  = (pos >= cnt8) && (pos < lim8);
        assign i_byte[gi] = ipq[qidx];
      end else begin : g_off
        assign i_hit[gi]  = 1'b0;
        assign i_byte[gi] = 8'd0;
      end
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    end_pc_d   = end_pc_q;
    disp_d     = disp_q;
    imm_d      = imm_q;
    dsz_d      = dsz_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    size_err_d = size_err_q;

    if (set_pc && (ce_1 || ce_2)) begin
      state_d    = IDLE;
      pc_d       = new_pc;
      end_pc_d   = new_pc;
      disp_d     = 16'd0;
      imm_d      = 32'd0;
      dsz_d      = 3'd0;
      rem_d      = 4'd0;
      cnt_d      = 4'd0;
      size_err_d = 1'b0;
    end else if (ce_1) begin
      size_err_d = 1'b0;
      if (accept) begin
        dsz_d      = dsat;
        rem_d      = rem_new;
        cnt_d      = 4'd0;
        disp_d     = 16'd0;
        imm_d      = 32'd0;
        end_pc_d   = pc_q;
        size_err_d = over;
        state_d    = (rem_new == 4'd0) ? DONE : FETCH;
      end else if ((state_q == DONE) && retire) begin
        state_d = IDLE;
      end else if (state_q == FETCH) begin
        pc_d     = pc_q + 16'(take8);
        end_pc_d = end_pc_q + 16'(take8);
        rem_d    = rem_q - take8[3:0];
        cnt_d    = cnt_q + take8[3:0];
        for (int k = 0; k < 2; k++) begin
          if (d_hit[k]) disp_d[8*k +: 8] = d_byte[k];
        end
        for (int k = 0; k < 4; k++) begin
          if (i_hit[k]) imm_d[8*k +: 8] = i_byte[k];
        end
        if (rem_d == 4'd0) state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pc_q       <= 16'd0;
      end_pc_q   <= 16'd0;
      disp_q     <= 16'd0;
      imm_q      <= 32'd0;
      dsz_q      <= 3'd0;
      rem_q      <= 4'd0;
      cnt_q      <= 4'd0;
      size_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      end_pc_q   <= end_pc_d;
      disp_q     <= disp_d;
      imm_q      <= imm_d;
      dsz_q      <= dsz_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      size_err_q <= size_err_d;
    end
  end

  assign pc       = pc_q;
  assign end_pc   = end_pc_q;
  assign disp     = disp_q;
  assign imm      = imm_q;
  assign size_err = size_err_q;
  assign busy     = (state_q == FETCH);
  // A redirect in flight invalidates the result before the edge lands.
  assign valid    = (state_q == DONE) && !set_pc;

endmodule
